// File: rtl/cs_adder_pkg.sv
// cs_adder_pkg: shared sizing helpers and operation encoding for the carry-select adder pipeline
package cs_adder_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  function automatic int nseg(input int w, input int s);
    return w / s;
  endfunction
  function automatic int nstg(input int w, input int s, input int p);
    return (nseg(w, s) + p - 1) / p;
  endfunction
endpackage

// File: rtl/cs_segment.sv
// cs_segment: one carry-select slice; both carry-in cases are summed up front and cin only picks one
module cs_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);
  logic [SEG:0] r0, r1;
  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + (SEG+1)'(1);
  assign {cout, sum} = cin ? r1 : r0;
  // the carry entering the top bit is whatever the top sum bit cannot explain from its own operands
  assign c_msb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
endmodule

// File: rtl/cs_adder_pipe.sv
// cs_adder_pipe: pipelined carry-select add/sub; each stage resolves SPS segments, valid/ready flow control
module cs_adder_pipe
  import cs_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int SPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf
);
  localparam int NSEG = nseg(WIDTH, SEG);
  localparam int NSTG = nstg(WIDTH, SEG, SPS);
  if (WIDTH % SEG != 0) begin : g_chk
    $error("cs_adder_pipe: WIDTH must be a multiple of SEG");
  end
  logic [NSTG-1:0] v_q, adv, ld;
  logic            init_q, dn_rdy;
  logic [WIDTH-1:0] a_q [NSTG], b_q [NSTG], q_q [NSTG];
  logic             c_q [NSTG], m_q [NSTG];
  logic [WIDTH-1:0] a_s [NSTG], b_s [NSTG], q_s [NSTG], q_d [NSTG];
  logic             c_s [NSTG], c_d [NSTG], m_d [NSTG];
  logic [WIDTH-1:0] seg_sum;
  logic             seg_m [NSEG];
  function automatic logic [WIDTH-1:0] smask(input int k);
    smask = '0;
    for (int j = 0; j < NSEG; j++)
      if (j / SPS == k) smask[j*SEG +: SEG] = '1;
  endfunction
  // stage inputs: ports for stage 0, previous stage register otherwise; b is pre-inverted for subtract
  always_comb begin
    a_s[0] = a;
    b_s[0] = (sub == OP_SUB) ? ~b : b;
    c_s[0] = (sub == OP_ADD) ? cin : 1'b1;
    q_s[0] = '0;
    for (int k = 1; k < NSTG; k++) begin
      a_s[k] = a_q[k-1];
      b_s[k] = b_q[k-1];
      c_s[k] = c_q[k-1];
      q_s[k] = q_q[k-1];
    end
  end
  for (genvar j = 0; j < NSEG; j++) begin : g_seg
    localparam int K = j / SPS;
    logic           ci, co;
    logic [SEG-1:0] s;
    if (j % SPS == 0) begin : g_first
      assign ci = c_s[K];
    end else begin : g_chain
      assign ci = g_seg[j-1].co;
    end
    cs_segment #(.SEG(SEG)) u_seg (
      .a    (a_s[K][j*SEG +: SEG]),
      .b    (b_s[K][j*SEG +: SEG]),
      .cin  (ci),
      .sum  (s),
      .cout (co),
      .c_msb(seg_m[j])
    );
    assign seg_sum[j*SEG +: SEG] = s;
    if (j % SPS == SPS-1 || j == NSEG-1) begin : g_last
      assign c_d[K] = co;
      assign m_d[K] = seg_m[j];
    end
  end
  always_comb begin
    for (int k = 0; k < NSTG; k++) q_d[k] = (seg_sum & smask(k)) | (q_s[k] & ~smask(k));
  end
  // ready ripples from the output back to stage 0 so bubbles collapse within one cycle
  always_comb begin
    dn_rdy = out_ready;
    for (int k = NSTG-1; k >= 0; k--) begin
      adv[k] = v_q[k] && dn_rdy;
      dn_rdy = !v_q[k] || adv[k];
    end
    ld[0] = in_valid && init_q && dn_rdy;
    for (int k = 1; k < NSTG; k++) ld[k] = adv[k-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q <= 1'b0;
      v_q    <= '0;
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        q_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
      end
    end else begin
      init_q <= 1'b1;
      for (int k = 0; k < NSTG; k++) begin
        v_q[k] <= ld[k] || (v_q[k] && !adv[k]);
        if (ld[k]) begin
          a_q[k] <= a_s[k];
          b_q[k] <= b_s[k];
          q_q[k] <= q_d[k];
          c_q[k] <= c_d[k];
          m_q[k] <= m_d[k];
        end
      end
    end
  end
  assign in_ready  = init_q && dn_rdy;
  assign out_valid = v_q[NSTG-1];
  assign q         = q_q[NSTG-1];
  assign cout      = c_q[NSTG-1];
  assign ovf       = c_q[NSTG-1] ^ m_q[NSTG-1];
endmodule
